// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
//   master: drives start, a, b; observes busy, done, diff, borrow, zero
//   slave : the subtractor side of the same signals
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );

endinterface

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor built from two half-subtractor stages.
//   x, y : minuend / subtrahend bits
//   bin  : borrow in
//   d    : difference bit  (x - y - bin)
//   bout : borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First half subtractor: x - y
    assign d1 = x ^ y;
    assign b1 = ~x & y;

    // Second half subtractor: (x - y) - bin
    assign d  = d1 ^ bin;
    assign b2 = ~d1 & bin;

    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b mod 2^WIDTH, one bit per
// clock LSB first through a single full-subtractor cell and borrow flop.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of serial_subtractor_if
//              start/a/b in; busy, done (1-cycle strobe), diff, borrow, zero out
// Results are staged in an internal shift register and copied to the
// outputs only in DONE, so diff/borrow/zero hold steady during SHIFT.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             bf;
    logic [CW-1:0]    cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    logic             d_c;
    logic             bnext_c;

    // Serial datapath cell operating on the current LSBs
    full_subtractor u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bf),
        .d    (d_c),
        .bout (bnext_c)
    );

    // FSM, counter, shift registers, borrow flop and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            bf       <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        res    <= '0;
                        bf     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // New difference bit enters at the MSB; after WIDTH
                    // shifts the first bit computed sits at bit 0.
                    res    <= {d_c, res[WIDTH-1:1]};
                    sa     <= {1'b0, sa[WIDTH-1:1]};
                    sb     <= {1'b0, sb[WIDTH-1:1]};
                    bf     <= bnext_c;
                    cnt    <= cnt + CW'(1);
                    busy_q <= 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q   <= 1'b1;
                    diff_q   <= res;
                    borrow_q <= bf;
                    zero_q   <= (res == '0);
                    busy_q   <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): a table of directed
// vectors plus hand-written sequences for ignored start, mid-operation reset
// and back-to-back operation.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
    } vec_t;

    vec_t vecs [6];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One full operation: pulse start, wait (bounded) for done, check timing and results.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_b,
                          input logic [7:0] ed, input logic eb, input logic ez,
                          input string tag);
        int         k;
        logic [7:0] prev;
        prev = bus.diff;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_b;
        check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 4) check({tag, " diff_hold_in_shift"}, 32'(bus.diff), 32'(prev));
            if (bus.done) break;
        end
        check({tag, " latency"}, 32'(k), 32'd9);
        check({tag, " diff"},    32'(bus.diff),   32'(ed));
        check({tag, " borrow"},  32'(bus.borrow), 32'(eb));
        check({tag, " zero"},    32'(bus.zero),   32'(ez));
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, " busy_fall"},      32'(bus.busy), 32'd0);
    endtask

    initial begin
        int k;
        int ndone;
        int k1;
        int k2;

        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{a: 8'd5,   b: 8'd3,   diff: 8'h02, borrow: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 8'd3,   b: 8'd5,   diff: 8'hFE, borrow: 1'b1, zero: 1'b0};
        vecs[2] = '{a: 8'h7A,  b: 8'h7A,  diff: 8'h00, borrow: 1'b0, zero: 1'b1};
        vecs[3] = '{a: 8'h00,  b: 8'hFF,  diff: 8'h01, borrow: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 8'hFF,  b: 8'h00,  diff: 8'hFF, borrow: 1'b0, zero: 1'b0};
        vecs[5] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F, borrow: 1'b0, zero: 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",   32'(bus.busy),   32'd0);
        check("reset done",   32'(bus.done),   32'd0);
        check("reset diff",   32'(bus.diff),   32'd0);
        check("reset borrow", 32'(bus.borrow), 32'd0);
        check("reset zero",   32'(bus.zero),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle no start busy", 32'(bus.busy), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].zero,
                   $sformatf("vec%0d", i));
        end

        // start during SHIFT is ignored: 9 - 4 with a 1 - 2 request mid-flight
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd9;
        bus.b = 8'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                bus.start = 1'b1;
                bus.a = 8'd1;
                bus.b = 8'd2;
            end
            if (c == 5) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                check("ignored_start done_cycle", 32'(c), 32'd9);
                check("ignored_start diff", 32'(bus.diff), 32'h05);
            end
        end
        check("ignored_start done_count", 32'(ndone), 32'd1);
        check("ignored_start idle_busy",  32'(bus.busy), 32'd0);

        // reset in the 4th SHIFT cycle aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset busy",   32'(bus.busy),   32'd0);
        check("midreset diff",   32'(bus.diff),   32'd0);
        check("midreset zero",   32'(bus.zero),   32'd1);
        check("midreset borrow", 32'(bus.borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("midreset no_done", 32'(ndone), 32'd0);
        run_op(8'd20, 8'd7, 8'h0D, 1'b0, 1'b0, "after_reset");

        // start held high: back-to-back operations every WIDTH+2 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'd10;
        bus.b = 8'd3;
        k1 = -1;
        k2 = -1;
        k = 0;
        while (k < 40 && k2 < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done) begin
                if (k1 < 0) k1 = k;
                else k2 = k;
            end
        end
        bus.start = 1'b0;
        check("b2b first_done",  32'(k1), 32'd10);
        check("b2b period",      32'(k2 - k1), 32'd10);
        check("b2b diff",        32'(bus.diff), 32'h07);
        repeat (13) @(posedge clk);
        #1;
        check("b2b idle_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
